// File: rtl/mult_share_arb.sv
// Round-robin front end that shares one sequential multiplier among N clients.
// Captures the winner's operands, issues a load, and returns the product or a timeout.
module mult_share_arb #(
    parameter int W      = 32,
    parameter int N      = 4,
    parameter int MAXLAT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_x,
    input  logic [N*(W-1)-1:0]   req_y,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         res_valid,
    output logic [2*W-1:0]       res,
    output logic                 err,
    output logic                 busy,
    output logic                 m_load,
    output logic [W-1:0]         m_x,
    output logic [W-2:0]         m_y,
    input  logic [2*W-1:0]       m_r,
    input  logic                 m_strobe
);

    localparam int IW  = $clog2(N);
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     own_q, own_d;
    logic [W-1:0]      x_q, x_d;
    logic [W-2:0]      y_q, y_d;
    logic [15:0]       wd_q, wd_d;
    logic [2*W-1:0]    res_q, res_d;
    logic              err_q, err_d;

    logic              found;
    logic [IW-1:0]     win;
    logic [IW1-1:0]    sum;
    logic [W-1:0]      win_x;
    logic [W-2:0]      win_y;

    // Scan from the rotating pointer so the last owner drops to lowest priority.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + IW1'(k);
            if (sum >= IW1'(N)) begin
                sum = sum - IW1'(N);
            end
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        win_x = '0;
        win_y = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IW'(i)) begin
                win_x = req_x[i*W +: W];
                win_y = req_y[i*(W-1) +: W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wd_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wd_q    <= wd_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        x_d     = x_q;
        y_d     = y_q;
        wd_d    = wd_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    own_d   = win;
                    x_d     = win_x;
                    y_d     = win_y;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                ptr_d   = (own_q == IW'(N-1)) ? '0 : own_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 16'd1;
                // A strobe in the final watchdog cycle still counts as success.
                if (m_strobe) begin
                    res_d   = m_r;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wd_q == 16'(MAXLAT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = '0;
        res_valid = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i]       = (state_q == ISSUE) && (own_q == IW'(i));
            res_valid[i] = (state_q == DONE) && (own_q == IW'(i));
        end
    end

    assign busy   = (state_q != IDLE);
    assign m_load = (state_q == ISSUE);
    assign m_x    = x_q;
    assign m_y    = y_q;
    assign res    = res_q;
    assign err    = err_q;

endmodule
